// File: rtl/norm_pkg.sv
// Shared types and constants for the Q16.16 normalizer: FSM state encoding,
// output widths and the exponent value loaded at the start of a scan.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MANT_W    = 64;
  localparam int K_W       = 6;
  localparam int LEAD_POS  = 62;
  localparam int FRAC_BITS = 16;

  // Exponent when the leading one already sits at operand bit 31.
  localparam logic [K_W-1:0] K_INIT = K_W'(31 - FRAC_BITS);

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter with an all-zero flag; cnt_o is 0 when the
// input is all zeros (callers qualify it with zero_o).
module lzc32 (
  input  logic [31:0] d_i,
  output logic [4:0]  cnt_o,
  output logic        zero_o
);

  always_comb begin
    // NOTE: assign a default before the loop so every path drives cnt_o and no latch is inferred.
    cnt_o = '0;
    for (int i = 0; i < 32; i++) begin
      if (d_i[i]) cnt_o = 5'(31 - i);
    end
  end

  assign zero_o = ~|d_i;

endmodule

// File: rtl/normalize_shift.sv
// Normalizes an unsigned Q16.16 operand so its leading one lands at bit 62.
// Define NORM_FAST_LZC_EN for a one-cycle SCAN using the leading-zero count.
module normalize_shift
  import norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       data_in,
  output logic              busy,
  output logic [MANT_W-1:0] shifted_mantissa,
  output logic [K_W-1:0]    k_out,
  output logic              zero,
  output logic              done
);

  state_t            state_q, state_d;
  logic [31:0]       operand_q;
  logic [MANT_W-1:0] sr_q;
  logic [K_W-1:0]    k_q;
  logic [MANT_W-1:0] mant_q;
  logic [K_W-1:0]    kout_q;
  logic              zero_q;
  logic              done_q;
  logic [4:0]        lzc;
  logic              op_zero;
  logic              accept;

  lzc32 u_lzc (
    .d_i    (operand_q),
    .cnt_o  (lzc),
    .zero_o (op_zero)
  );

  // The cycle done is high is spent in IDLE but must not accept a new start.
  assign accept = start && !done_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: state_d = op_zero ? DONE : SCAN;
`ifdef NORM_FAST_LZC_EN
      SCAN: state_d = DONE;
`else
      SCAN: if (sr_q[LEAD_POS]) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand_q <= '0;
      sr_q      <= '0;
      k_q       <= '0;
      mant_q    <= '0;
      kout_q    <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) operand_q <= data_in;
        LOAD: begin
          sr_q <= {1'b0, operand_q, 31'b0};
          k_q  <= K_INIT;
        end
        SCAN: begin
`ifdef NORM_FAST_LZC_EN
          sr_q <= sr_q << lzc;
          k_q  <= K_INIT - K_W'(lzc);
`else
          if (!sr_q[LEAD_POS]) begin
            sr_q <= sr_q << 1;
            k_q  <= k_q - K_W'(1);
          end
`endif
        end
        DONE: begin
          mant_q <= op_zero ? '0 : sr_q;
          kout_q <= op_zero ? '0 : k_q;
          zero_q <= op_zero;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef NORM_FAST_LZC_EN
  logic unused_lzc;
  assign unused_lzc = ^lzc;
`endif

  assign shifted_mantissa = mant_q;
  assign k_out            = kout_q;
  assign zero             = zero_q;
  assign done             = done_q;

endmodule

// File: tb/tb_normalize_shift.sv
// Self-checking bench for normalize_shift: directed table, random operands
// against an arithmetic model, busy/done-cycle start rejection and mid-scan reset.
module tb_normalize_shift;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic [63:0] shifted_mantissa;
  logic [5:0]  k_out;
  logic        zero;
  logic        done;

  int n_vec  = 0;
  int n_fail = 0;

  normalize_shift dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .data_in          (data_in),
    .busy             (busy),
    .shifted_mantissa (shifted_mantissa),
    .k_out            (k_out),
    .zero             (zero),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] din;
    logic [63:0] mant;
    logic [5:0]  k;
    logic        z;
    int          lat_slow;
    int          lat_fast;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int exp_latency(input int slow, input int fast);
`ifdef NORM_FAST_LZC_EN
    return fast;
`else
    return slow;
`endif
  endfunction

  // Reference: position of the leading one by magnitude comparison, then scale by a power of two.
  task automatic model(input logic [31:0] x, output logic [63:0] m, output logic [5:0] k,
                       output logic z, output int lat);
    int p;
    if (x == 32'd0) begin
      m = '0; k = '0; z = 1'b1; lat = 2;
    end else begin
      p = 0;
      for (int b = 0; b < 32; b++) if ({32'd0, x} >= (64'd1 << b)) p = b;
      m   = {32'd0, x} * (64'd1 << (62 - p));
      k   = 6'(p - 16);
      z   = 1'b0;
      lat = exp_latency(34 - p, 3);
    end
  endtask

  // Pulses start with x, then counts cycles from the sampling edge until done.
  task automatic run_op(input logic [31:0] x, output logic [63:0] m, output logic [5:0] k,
                        output logic z, output int lat);
    @(negedge clk);
    start   = 1'b1;
    data_in = x;
    @(negedge clk);
    start   = 1'b0;
    data_in = $urandom;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    m = shifted_mantissa;
    k = k_out;
    z = zero;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  vec_t        vecs[6];
  logic [63:0] m, em;
  logic [5:0]  k, ek;
  logic        z, ez;
  int          lat, elat;
  logic [31:0] x;
  int          ndone;

  initial begin
    vecs[0] = '{32'h0001_0000, 64'h4000_0000_0000_0000, 6'd0,       1'b0, 18, 3};
    vecs[1] = '{32'h0001_8000, 64'h6000_0000_0000_0000, 6'd0,       1'b0, 18, 3};
    vecs[2] = '{32'h8000_0000, 64'h4000_0000_0000_0000, 6'b001111,  1'b0, 3,  3};
    vecs[3] = '{32'h0000_0001, 64'h4000_0000_0000_0000, 6'b110000,  1'b0, 34, 3};
    vecs[4] = '{32'h0000_0000, 64'h0,                   6'd0,       1'b1, 2,  2};
    vecs[5] = '{32'hFFFF_FFFF, 64'h7FFF_FFFF_8000_0000, 6'b001111,  1'b0, 3,  3};

    rst = 1'b0; start = 1'b0; data_in = '0;
    #23;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    check("reset_k",    64'(k_out), 64'd0);
    check("reset_mant", shifted_mantissa, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].din, m, k, z, lat);
      check($sformatf("tbl%0d_mant", i), m, vecs[i].mant);
      check($sformatf("tbl%0d_k", i), 64'(k), 64'(vecs[i].k));
      check($sformatf("tbl%0d_zero", i), 64'(z), 64'(vecs[i].z));
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(exp_latency(vecs[i].lat_slow, vecs[i].lat_fast)));
    end

    for (int i = 0; i < 25; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if (i == 7) x = 32'd0;
      model(x, em, ek, ez, elat);
      run_op(x, m, k, z, lat);
      check($sformatf("rnd%0d_mant(%h)", i, x), m, em);
      check($sformatf("rnd%0d_k(%h)", i, x), 64'(k), 64'(ek));
      check($sformatf("rnd%0d_zero(%h)", i, x), 64'(z), 64'(ez));
      check($sformatf("rnd%0d_lat(%h)", i, x), 64'(lat), 64'(elat));
    end

    // Second start while busy must be ignored: one done, first operand's results.
    model(32'h0000_0100, em, ek, ez, elat);
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_0100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_during_op", 64'(busy), 64'd1);
    start = 1'b1; data_in = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        ndone++;
        m = shifted_mantissa; k = k_out;
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 64'(ndone), 64'd1);
    check("busy_start_mant", m, em);
    check("busy_start_k", 64'(k), 64'(ek));

    // Start presented in the done cycle must be ignored.
    @(negedge clk);
    start = 1'b1; data_in = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && !done; c++) @(negedge clk);
    start = 1'b1; data_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_cycle_start_no_op", 64'(busy), 64'd0);

    // Reset in the middle of a long scan aborts with all outputs cleared.
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_mant", shifted_mantissa, 64'd0);
    check("midreset_k", 64'(k_out), 64'd0);
    check("midreset_zero", 64'(zero), 64'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midreset_no_done", 64'(ndone), 64'd0);
    model(32'h0012_3456, em, ek, ez, elat);
    run_op(32'h0012_3456, m, k, z, lat);
    check("post_reset_mant", m, em);
    check("post_reset_k", 64'(k), 64'(ek));
    check("post_reset_lat", 64'(lat), 64'(elat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
